// File: rtl/md_sequencer_if.sv
// Request/response bundle between stage E and the HI/LO multiply/divide sequencer.
// The master drives the request; the slave (sequencer) returns status and HI/LO.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, d1, d2, input busy, done, hi, lo);
  modport slave  (input start, op, d1, d2, output busy, done, hi, lo);
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div controller owning the MIPS HI/LO pair: the result is computed
// at acceptance, held in a shadow pair, and committed after a fixed latency.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [31:0] res_hi, res_lo, res_hi_next, res_lo_next;
  logic [31:0] hi_reg, lo_reg, hi_next, lo_next;
  logic        done_reg, done_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_s, div_u;
  logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

  assign prod_s = {{32{bus.d1[31]}}, bus.d1} * {{32{bus.d2[31]}}, bus.d2};
  assign prod_u = {32'd0, bus.d1} * {32'd0, bus.d2};

  // Signed divide on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign mag_a  = bus.d1[31] ? (~bus.d1 + 32'd1) : bus.d1;
  assign mag_b  = bus.d2[31] ? (~bus.d2 + 32'd1) : bus.d2;
  assign div_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign div_u  = (bus.d2 == 32'd0) ? 32'd1 : bus.d2;
  assign q_mag  = mag_a / div_s;
  assign r_mag  = mag_a % div_s;
  assign quot_s = (bus.d1[31] ^ bus.d2[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s  = bus.d1[31] ? (~r_mag + 32'd1) : r_mag;
  assign quot_u = bus.d1 / div_u;
  assign rem_u  = bus.d1 % div_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    res_hi_next = res_hi;
    res_lo_next = res_lo;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              {res_hi_next, res_lo_next} = prod_s;
              count_next = MUL_LOAD;
              state_next = MUL;
            end
            OP_MULTU: begin
              {res_hi_next, res_lo_next} = prod_u;
              count_next = MUL_LOAD;
              state_next = MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.d2 == 32'd0) begin
                res_hi_next = bus.d1;
                res_lo_next = 32'hFFFF_FFFF;
              end else if (bus.op == OP_DIV) begin
                res_hi_next = rem_s;
                res_lo_next = quot_s;
              end else begin
                res_hi_next = rem_u;
                res_lo_next = quot_u;
              end
              count_next = DIV_LOAD;
              state_next = DIV;
            end
            OP_MTHI: begin
              hi_next   = bus.d1;
              done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next   = bus.d1;
              done_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (count != '0) begin
          count_next = count - 1'b1;
        end else begin
          hi_next    = res_hi;
          lo_next    = res_lo;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      count    <= count_next;
      res_hi   <= res_hi_next;
      res_lo   <= res_lo_next;
      hi_reg   <= hi_next;
      lo_reg   <= lo_next;
      done_reg <= done_next;
    end
  end

  assign bus.busy = (state == MUL) || (state == DIV);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, HI/LO results, mthi/mtlo, ignored starts
// and asynchronous reset, all against hand-computed values.
module tb_md_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;

  md_sequencer_if bus ();

  md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rise.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.d1    = a;
    bus.d2    = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns on the falling edge where done is expected high.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic [31:0] old_hi);
    int n;
    n = 0;
    applyStimulus(op, a, b);
    checkOutput({tag, " stale hi"}, bus.hi, old_hi);
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
    checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, " hi"}, bus.hi, exp_hi);
    checkOutput({tag, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int n;
    int dc;
    int busy_seen;
    bit injected;

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.d1    = '0;
    bus.d2    = '0;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    #2;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset hi", bus.hi, 32'd0);
    checkOutput("reset lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    runOp("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0);
    // Next start lands on the done cycle, which must be accepted.
    runOp("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("done single pulse", 32'(bus.done), 32'd0);

    runOp("div neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    runOp("divu by zero", 3'b011, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 32'd7);
    runOp("div neg divisor", 3'b010, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 32'd0);
    @(negedge clk);

    bus.start = 1'b1; bus.op = 3'b100; bus.d1 = 32'h1234_5678;
    @(negedge clk);
    checkOutput("mthi hi", bus.hi, 32'h1234_5678);
    checkOutput("mthi busy", 32'(bus.busy), 32'd0);
    checkOutput("mthi done", 32'(bus.done), 32'd1);
    bus.op = 3'b101; bus.d1 = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mtlo lo", bus.lo, 32'h9ABC_DEF0);
    checkOutput("mtlo hi kept", bus.hi, 32'h1234_5678);
    checkOutput("mtlo busy", 32'(bus.busy), 32'd0);
    checkOutput("mtlo done", 32'(bus.done), 32'd1);
    @(negedge clk);
    checkOutput("mtlo done clear", 32'(bus.done), 32'd0);

    // 100 / 7 = 14 rem 2, with a mult start injected on busy cycle 3.
    applyStimulus(3'b010, 32'd100, 32'd7);
    n = 0; dc = 0; injected = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.busy) n++;
      if (bus.done) dc++;
      if (bus.busy && n == 3 && !injected) begin
        injected = 1'b1;
        $display("[TB] warning: start issued while busy (protocol violation, expected to be ignored)");
        bus.start = 1'b1; bus.op = 3'b000; bus.d1 = 32'd5; bus.d2 = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("ignored start busy cycles", 32'(n), 32'd10);
    checkOutput("ignored start done count", 32'(dc), 32'd1);
    checkOutput("ignored start hi", bus.hi, 32'd2);
    checkOutput("ignored start lo", bus.lo, 32'd14);

    applyStimulus(3'b110, 32'hDEAD_BEEF, 32'd1);
    checkOutput("reserved busy", 32'(bus.busy), 32'd0);
    checkOutput("reserved done", 32'(bus.done), 32'd0);
    checkOutput("reserved hi", bus.hi, 32'd2);
    checkOutput("reserved lo", bus.lo, 32'd14);

    applyStimulus(3'b000, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(bus.busy), 32'd0);
    checkOutput("async reset hi", bus.hi, 32'd0);
    checkOutput("async reset lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dc = 0; busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
      if (bus.busy) busy_seen++;
    end
    checkOutput("post reset done count", 32'(dc), 32'd0);
    checkOutput("post reset busy count", 32'(busy_seen), 32'd0);
    checkOutput("post reset hi", bus.hi, 32'd0);
    checkOutput("post reset lo", bus.lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair for the pipelined MIPS core.
- Accepts one operation per request from stage E.
- Raises busy for a fixed, parameterised latency, then commits the result to HI/LO.
- Handles single-cycle mthi/mtlo writes. The stall unit reads busy/start to hold mfhi/mflo/mult/div instructions in stage D.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, width of the latency counter; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  input  1  request strobe, valid for one cycle.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others reserved (no-op).
- d1  input  32  operand A (rs value, already forwarded).
- d2  input  32  operand B (rt value, already forwarded).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on the cycle the new HI/LO becomes visible.
- hi  output  32  committed HI.
- lo  output  32  committed LO.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. Any pending result is discarded.
- FSM states: IDLE, MUL, DIV. busy=1 exactly when state is MUL or DIV (registered output).
- IDLE with start=1 and op=mult/multu:
  - Latch the 64-bit product into internal res_hi/res_lo at this edge.
  - Signed product for mult, unsigned for multu.
  - counter=MUL_CYCLES-1; go to MUL.
- IDLE with start=1 and op=div/divu:
  - Latch lo=quotient and hi=remainder into res_lo/res_hi.
  - Signed: quotient truncates toward zero; remainder takes the sign of d1.
  - d1=0x80000000, d2=0xFFFFFFFF (signed): res_lo=0x80000000, res_hi=0.
  - d2=0: res_lo=0xFFFFFFFF, res_hi=d1 for both div and divu.
  - counter=DIV_CYCLES-1; go to DIV.
- IDLE with start=1 and op=mthi/mtlo:
  - hi<=d1 (or lo<=d1) at this edge.
  - busy stays 0; done pulses the following cycle.
- MUL/DIV states:
  - If counter!=0, decrement.
  - If counter==0: hi<=res_hi, lo<=res_lo, state<=IDLE, done<=1 for one cycle.
- Latency: a start at edge k gives busy=1 on cycles k+1..k+N, where N=MUL_CYCLES or DIV_CYCLES. hi/lo update at edge k+N; done=1 on cycle k+N+1.
- start while busy=1 is ignored: no state change and the in-flight result is kept. This is a protocol violation the stall unit prevents; the bench flags it only as a warning.
- Reserved op with start=1: no effect.
- hi/lo hold the old values for the whole busy window, so mfhi during busy would read stale data. The pipeline stalls to prevent this.
- done and start on the same cycle is allowed; the new start is accepted because state is already IDLE.
- Reset asserted mid-operation: the result is never committed, and hi/lo read 0 after reset.
- Counter saturates; it never wraps below 0.

Test Plan:
- Reset then mult d1=0xFFFFFFFE, d2=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- multu d1=0xFFFFFFFF, d2=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div d1=-7 (0xFFFFFFF9), d2=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> lo=0xFFFFFFFF, hi=7.
- mthi d1=0x12345678 then mtlo d1=0x9ABCDEF0 on consecutive cycles -> busy never asserts; hi/lo show the values one edge after each start.
- Start div, then a second start (mult) at busy cycle 3 -> the second start is ignored; after 10 cycles the div result commits and done pulses once.
- Start mult, drop reset to 0 at busy cycle 2 -> busy=0, hi=lo=0 immediately (asynchronous); after reset release hi/lo stay 0 and done never pulses.
